mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory of the multi-cycle CPU. It shares the memory between the CPU memory interface (port C) and a DMA/peripheral master (port D). It latches each winning request, drives the memory strobes for exactly one cycle, waits the memory read latency, and returns a one-cycle acknowledge with read data. CPU has priority; a starvation counter guarantees DMA progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (≥1): mem_rdata valid MEM_LAT cycles after the mem_re cycle
- STARVE_MAX, 4, consecutive DMA losses before DMA is forced to win (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- c_req / d_req  in  1  request; held high with fields stable until matching ack
- c_we / d_we  in  1  1 = write, 0 = read
- c_addr / d_addr  in  ADDR_W  word address
- c_wdata / d_wdata  in  DATA_W  write data
- c_ack / d_ack  out  1  one-cycle completion pulse
- c_rdata / d_rdata  out  DATA_W  registered read data, valid while ack=1, held until next read for that port
- mem_re / mem_we  out  1  memory strobes (never both 1)
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  1 in any state except IDLE
- owner  out  1  0 = CPU, 1 = DMA; current or last grantee

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests are sampled only here. Rules, in order:
  - no request: stay; starvation counter cleared.
  - only one requester: that requester wins.
  - both requesting and starve_cnt == STARVE_MAX: DMA wins.
  - both requesting otherwise: CPU wins.
- On a win, latch owner, we, addr and wdata into mem_addr/mem_wdata, then go to ISSUE.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - +1 when both request and CPU wins.
  - cleared when DMA wins or d_req=0 in IDLE.
  - never exceeds STARVE_MAX.
- ISSUE: one cycle with mem_we=latched we and mem_re=!we.
  - Write → DONE.
  - Read → WAIT.
- WAIT: counts MEM_LAT cycles. On the last one, capture mem_rdata into the owner's rdata register. Then go to DONE.
- DONE: owner's ack=1 for exactly one cycle, then go to IDLE.
- Request fields changing after grant are ignored. Dropping req after grant does not cancel the transaction.
- Non-owner ack stays 0. Non-owner rdata is unchanged.
- A requester holding req through ack issues a new transaction. It is re-arbitrated in the following IDLE cycle.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, starve_cnt=0, owner=0.
  - all acks, mem_re, mem_we, busy = 0.
  - mem_addr, mem_wdata, c_rdata, d_rdata = 0.
- Reset asserted mid-transaction aborts it immediately. Strobes and acks drop combinationally with reset, and no ack is ever issued for the aborted request.
- Request first seen in IDLE in cycle t:
  - ISSUE at t+1.
  - Write: ack at t+2.
  - Read: WAIT t+2..t+1+MEM_LAT, ack at t+2+MEM_LAT (t+3 for MEM_LAT=1).
- Next arbitration is in cycle ack+1. Minimum spacing is 3 cycles per write and 3+MEM_LAT per read.
- All outputs are registered or decoded directly from state. No combinational path from req to any output.

## Test plan
- CPU read, MEM_LAT=1, c_addr=0x10, memory returns 0xDEADBEEF: mem_re=1 only at t+1 with mem_addr=0x10; c_ack=1 only at t+3 with c_rdata=0xDEADBEEF; d_ack stays 0.
- DMA write alone, d_addr=0x20, d_wdata=0x12345678: mem_we=1 at t+1 with matching addr/data; d_ack at t+2; busy=1 for t+1..t+2.
- Starvation, STARVE_MAX=4, c_req and d_req both held high continuously: grant sequence C,C,C,C,D,C,C,C,C,D; starve_cnt=0 after each DMA grant.
- MEM_LAT=3 read: ack exactly 5 cycles after the IDLE sample; mem_rdata changed at any non-capture cycle has no effect on rdata.
- Field stability: change c_addr to 0x99 and drop c_req the cycle after grant: memory still sees the original address and c_ack still pulses once.
- Reset low during WAIT: mem_re, acks and busy go to 0 immediately; after release, IDLE with no ack pulse; a new request completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Purpose  : Shares one single-ported memory between a CPU port (C) and a  |
// |            DMA port (D). Each winning request is latched, issued to the  |
// |            memory for one cycle, read data is captured after MEM_LAT     |
// |            cycles, and a one-cycle ack is returned to the winner. CPU    |
// |            has priority; a starvation counter forces a DMA win after     |
// |            STARVE_MAX consecutive losses.                                |
// | Ports    : clk, reset (async, active-low)                                |
// |            c_req/c_we/c_addr/c_wdata -> c_ack/c_rdata   (CPU port)       |
// |            d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   (DMA port)       |
// |            mem_re/mem_we/mem_addr/mem_wdata, mem_rdata  (memory side)    |
// |            busy (not IDLE), owner (0 = CPU, 1 = DMA)                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  // Latency counter runs 0..MEM_LAT-1 while in WAIT.
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              d_wins;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    d_wins      = 1'b0;

    case (state_q)
      IDLE: begin
        // Contention goes to the CPU unless the DMA has lost STARVE_MAX times.
        if (c_req && d_req) d_wins = (starve_q == STARVE_LIM);
        else                d_wins = d_req;

        // Only a CPU win over a waiting DMA counts as a loss; every other
        // IDLE outcome (no request, DMA absent, DMA wins) clears the count.
        if (c_req && d_req && !d_wins) starve_d = starve_q + SW'(1);
        else                           starve_d = '0;

        if (c_req || d_req) begin
          owner_d     = d_wins;
          we_d        = d_wins ? d_we    : c_we;
          mem_addr_d  = d_wins ? d_addr  : c_addr;
          mem_wdata_d = d_wins ? d_wdata : c_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = '0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          if (owner_q) d_rdata_d = mem_rdata;
          else         c_rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      starve_q    <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
    end
  end

  // Strobes, acks and busy decode from state only, so the asynchronous
  // state reset removes them immediately and no request input reaches them.
  assign mem_re    = (state_q == ISSUE) && !we_q;
  assign mem_we    = (state_q == ISSUE) &&  we_q;
  assign c_ack     = (state_q == DONE)  && !owner_q;
  assign d_ack     = (state_q == DONE)  &&  owner_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                           |
// | Purpose  : Scoreboard bench for mem_port_arbiter (MEM_LAT=3,             |
// |            STARVE_MAX=4). A transaction-level model predicts each grant, |
// |            memory issue cycle, ack cycle and read data; a negedge        |
// |            monitor compares every DUT output against it each cycle.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
  logic        c_ack, d_ack, mem_re, mem_we, busy, owner;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          issue;
    int          ack;
  } txn_t;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  txn_t        q[$];
  int          next_arb = 0;
  int          starve = 0;
  logic        last_owner = 1'b0;
  logic [31:0] exp_rd[2];
  int          gnt_cnt[2];
  logic        log_en = 1'b0;
  logic        ack_log[$];
  logic [31:0] ram[int];
  logic [31:0] mdl[int];
  int          rd_due = -1;
  int          rd_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return 32'(a) * 32'h9E3779B1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Memory environment: writes land on the strobe cycle; read data is only
  // valid MEM_LAT cycles after mem_re, random noise on every other cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) ram[int'(mem_addr[7:0])] = mem_wdata;
      if (mem_re) begin
        rd_due  = cyc + MEM_LAT;
        rd_addr = int'(mem_addr[7:0]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cyc == rd_due) mem_rdata = ram.exists(rd_addr) ? ram[rd_addr] : init_val(rd_addr);
    else               mem_rdata = $urandom;
  end

  // Monitor + reference model.
  txn_t e, n;
  logic have, act, win;
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_c_ack", 32'(c_ack), 0);
      chk("rst_d_ack", 32'(d_ack), 0);
      chk("rst_mem_re", 32'(mem_re), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_c_rdata", c_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      q.delete();
      starve     = 0;
      last_owner = 1'b0;
      exp_rd[0]  = '0;
      exp_rd[1]  = '0;
      next_arb   = 0;
    end else begin
      have = (q.size() > 0);
      if (have) e = q[0];
      act = have && (cyc >= e.issue);
      if (have && cyc == e.ack && !e.we) exp_rd[e.port] = e.rdata;
      chk("busy", 32'(busy), 32'(act));
      chk("owner", 32'(owner), 32'(act ? e.port : last_owner));
      chk("mem_re", 32'(mem_re), 32'(have && cyc == e.issue && !e.we));
      chk("mem_we", 32'(mem_we), 32'(have && cyc == e.issue && e.we));
      chk("c_ack", 32'(c_ack), 32'(have && cyc == e.ack && !e.port));
      chk("d_ack", 32'(d_ack), 32'(have && cyc == e.ack && e.port));
      chk("c_rdata", c_rdata, exp_rd[0]);
      chk("d_rdata", d_rdata, exp_rd[1]);
      if (have && cyc == e.issue) begin
        chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
      if (log_en && (c_ack || d_ack)) ack_log.push_back(d_ack);
      if (have && cyc == e.ack) begin
        last_owner = e.port;
        void'(q.pop_front());
        next_arb = cyc + 1;
      end
      // Arbitration: only when no transaction is outstanding.
      if (q.size() == 0 && cyc >= next_arb) begin
        if (!c_req && !d_req) begin
          starve = 0;
        end else begin
          if (c_req && d_req) begin
            if (starve == STARVE_MAX) begin win = 1'b1; starve = 0; end
            else begin win = 1'b0; starve++; end
          end else begin
            win    = d_req;
            starve = 0;
          end
          n.port  = win;
          n.we    = win ? d_we : c_we;
          n.addr  = win ? d_addr : c_addr;
          n.wdata = win ? d_wdata : c_wdata;
          n.issue = cyc + 1;
          n.ack   = n.we ? cyc + 2 : cyc + 2 + MEM_LAT;
          n.rdata = mdl.exists(int'(n.addr[7:0])) ? mdl[int'(n.addr[7:0])] : init_val(int'(n.addr[7:0]));
          if (n.we) mdl[int'(n.addr[7:0])] = n.wdata;
          q.push_back(n);
          gnt_cnt[win]++;
        end
      end
    end
  end

  task automatic set_port(input logic p, input logic r, input logic we,
                          input logic [31:0] a, input logic [31:0] wd);
    if (!p) begin c_req = r; c_we = we; c_addr = a; c_wdata = wd; end
    else    begin d_req = r; d_we = we; d_addr = a; d_wdata = wd; end
  endtask

  // One transaction on port p; scr=1 scrambles fields and drops req the
  // cycle after the grant, which must not affect the transaction.
  task automatic drive(input logic p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic scr);
    int base;
    int k;
    @(posedge clk); #1;
    base = gnt_cnt[p];
    set_port(p, 1'b1, we, a, wd);
    k = 0;
    while (gnt_cnt[p] == base && k < 300) begin @(posedge clk); #1; k++; end
    if (gnt_cnt[p] == base) begin
      chk("grant_timeout", 32'(p), 32'hFFFF_FFFF);
      set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
      return;
    end
    if (scr) set_port(p, 1'b0, ~we, 32'h99, $urandom);
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      if (p ? d_ack : c_ack) break;
      k++;
    end
    if (k == 300) chk("ack_timeout", 32'(p), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Both ports request continuously; each ack immediately starts a new
  // transaction on that port.
  task automatic hold_both(input int nacks);
    int   cnt;
    int   guard;
    logic p;
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
    set_port(1'b1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
    cnt = 0;
    guard = 0;
    while (cnt < nacks && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (c_ack || d_ack) begin
        p = d_ack;
        cnt++;
        @(posedge clk); #1;
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
      end
    end
    if (cnt < nacks) chk("hold_timeout", 32'(cnt), 32'(nacks));
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic exp_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    gnt_cnt[0] = 0;
    gnt_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);

    // CPU read of a preloaded word, then a lone DMA write.
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("cpu_read_data", c_rdata, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    repeat (2) @(posedge clk);

    // Starvation: both held high.
    log_en = 1'b1;
    hold_both(10);
    log_en = 1'b0;
    chk("grant_seq_len", 32'(ack_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      chk("grant_seq", 32'(ack_log[i]), 32'(exp_seq[i]));
    repeat (2) @(posedge clk);

    // Field changes and req drop after grant are ignored.
    drive(1'b0, 1'b0, 32'h40, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h41, 32'hCAFEF00D, 1'b1);

    // Randomised concurrent traffic.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          drive(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                $urandom, 1'($urandom_range(0, 3) == 0));
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          drive(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                $urandom, 1'($urandom_range(0, 3) == 0));
        end
      end
    join
    repeat (3) @(posedge clk);

    // Reset asserted during WAIT aborts the read with no ack.
    begin
      int base;
      int k;
      @(posedge clk); #1;
      base = gnt_cnt[0];
      set_port(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
      k = 0;
      while (gnt_cnt[0] == base && k < 300) begin @(posedge clk); #1; k++; end
      chk("rst_test_grant", 32'(gnt_cnt[0] != base), 32'd1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_mem_re", 32'(mem_re), 0);
      chk("abort_mem_we", 32'(mem_we), 0);
      chk("abort_c_ack", 32'(c_ack), 0);
      chk("abort_d_ack", 32'(d_ack), 0);
      chk("abort_busy", 32'(busy), 0);
      set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      repeat (4) @(posedge clk);
    end
    drive(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
